// File: rtl/key_pkg.sv
// Shared types and helpers for the key-to-digit input stage.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        REPEAT,
        DEB_REL
    } key_state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Bits needed to hold values 0..n (never narrower than one bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_digit_input_if.sv
// Link between a key debouncer and the controller that consumes its result.
interface key_digit_input_if;
    logic key_n;    // raw active-low key, asynchronous
    logic pressed;  // synchronized sample, active high
    logic held;     // debouncer sits in its stable-pressed state
    logic level;    // debounced level (pressed, including release debounce)
    logic press;    // one-cycle pulse on the accepting sample edge

    modport deb (input key_n, output pressed, held, level, press);
    modport ctl (output key_n, input pressed, held, level, press);
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus press/release debouncer, advanced only on SMP.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEB_CNT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             smp_i,
    key_digit_input_if.deb   bus
);

    localparam int            CW       = cnt_w(DEB_CNT);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CNT - 1);

    logic          sync1_q, sync2_q;
    logic          pressed;
    key_state_t    state_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.key_n;
            sync2_q <= sync1_q;
        end
    end

    assign pressed     = ~sync2_q;
    assign bus.pressed = pressed;
    assign bus.held    = (state_q == HELD);
    assign bus.level   = (state_q == HELD) || (state_q == DEB_REL);

    // Decoded from current state so the digit can change on the accepting edge itself.
    assign bus.press = smp_i && pressed &&
                       (((state_q == IDLE) && (DEB_CNT == 1)) ||
                        ((state_q == DEB_PRESS) && (cnt_q == DEB_LAST)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (smp_i) begin
            case (state_q)
                IDLE: begin
                    if (pressed) begin
                        if (DEB_CNT == 1) begin
                            state_q <= HELD;
                        end else begin
                            state_q <= DEB_PRESS;
                            cnt_q   <= CW'(1);
                        end
                    end
                end
                DEB_PRESS: begin
                    if (!pressed) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        if (DEB_CNT == 1) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DEB_REL;
                            cnt_q   <= CW'(1);
                        end
                    end
                end
                DEB_REL: begin
                    if (pressed) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_digit_input.sv
// Debounced increment/clear keys driving a single decimal digit with auto-repeat.
module key_digit_input
    import key_pkg::*;
#(
    parameter int SAMPLE_DIV  = 250000,
    parameter int DEB_CNT     = 4,
    parameter int REPEAT_DLY  = 100,
    parameter int REPEAT_RATE = 20
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       nKEY_INC,
    input  logic       nKEY_CLR,
    output logic [3:0] DOUT,
    output logic       UPD
);

    localparam int            PW        = cnt_w(SAMPLE_DIV - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(SAMPLE_DIV - 1);
    localparam int            HW        = cnt_w(REPEAT_DLY);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DLY - 1);
    localparam int            RW        = cnt_w(REPEAT_RATE);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic [PW-1:0] pre_q;
    logic          smp;

    key_state_t    rep_state_q;
    logic [HW-1:0] hold_q;
    logic [RW-1:0] rate_q;
    logic          rep_inc;
    logic          hold_smp;

    logic [3:0]    dout_q, dout_d;
    logic          upd_q, upd_d;

    key_digit_input_if inc_bus ();
    key_digit_input_if clr_bus ();

    assign inc_bus.key_n = nKEY_INC;
    assign clr_bus.key_n = nKEY_CLR;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pre_q <= '0;
        end else if (smp) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    assign smp = (pre_q == PRE_LAST);

    key_debounce #(.DEB_CNT(DEB_CNT)) u_inc_deb (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .smp_i  (smp),
        .bus    (inc_bus)
    );

    key_debounce #(.DEB_CNT(DEB_CNT)) u_clr_deb (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .smp_i  (smp),
        .bus    (clr_bus)
    );

    // Only samples taken while stable-pressed advance hold/rate; the sample that
    // bounces back from release debounce is excluded.
    assign hold_smp = smp && inc_bus.held && inc_bus.pressed && !inc_bus.press;
    assign rep_inc  = hold_smp && (rep_state_q == REPEAT) && (rate_q == RATE_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rep_state_q <= IDLE;
            hold_q      <= '0;
            rate_q      <= '0;
        end else if (smp) begin
            if (inc_bus.press) begin
                rep_state_q <= HELD;
                hold_q      <= '0;
                rate_q      <= '0;
            end else if (hold_smp) begin
                if (rep_state_q == HELD) begin
                    hold_q <= hold_q + HW'(1);
                    if (hold_q == HOLD_LAST) begin
                        rep_state_q <= REPEAT;
                        rate_q      <= '0;
                    end
                end else if (rep_state_q == REPEAT) begin
                    rate_q <= (rate_q == RATE_LAST) ? '0 : rate_q + RW'(1);
                end
            end else if (!inc_bus.level) begin
                rep_state_q <= IDLE;
            end
        end
    end

    // Clear has priority over any increment landing on the same edge.
    always_comb begin
        dout_d = dout_q;
        upd_d  = 1'b0;
        if (clr_bus.press) begin
            dout_d = 4'd0;
            upd_d  = 1'b1;
        end else if (inc_bus.press || rep_inc) begin
            dout_d = (dout_q >= DIGIT_MAX) ? 4'd0 : dout_q + 4'd1;
            upd_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dout_q <= 4'd0;
            upd_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            upd_q  <= upd_d;
        end
    end

    assign DOUT = dout_q;
    assign UPD  = upd_q;

endmodule

// File: tb/tb_key_digit_input.sv
// Directed bench for key_digit_input; every UPD pops an expected digit from a scoreboard.
module tb_key_digit_input;

    localparam int SD = 4;
    localparam int DC = 3;
    localparam int RD = 8;
    localparam int RR = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dout;
    logic       upd;

    int total   = 0;
    int bad     = 0;
    int upd_cnt = 0;
    logic [3:0] exp_q[$];

    key_digit_input_if inc_if ();
    key_digit_input_if clr_if ();

    key_digit_input #(
        .SAMPLE_DIV  (SD),
        .DEB_CNT     (DC),
        .REPEAT_DLY  (RD),
        .REPEAT_RATE (RR)
    ) dut (
        .CLK      (clk),
        .nRST     (rst_n),
        .nKEY_INC (inc_if.key_n),
        .nKEY_CLR (clr_if.key_n),
        .DOUT     (dout),
        .UPD      (upd)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks; sample #1 after each rising edge and score any UPD.
    task automatic tick(input int n);
        logic [3:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (upd === 1'b1) begin
                upd_cnt++;
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL upd_unexpected: observed UPD with dout=%0d expected no UPD", dout);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check4("upd_dout", dout, e);
                end
            end
        end
    endtask

    task automatic samp(input int n);
        tick(n * SD);
    endtask

    task automatic press(input logic inc, input logic clr, input int lo, input int hi);
        inc_if.key_n = ~inc;
        clr_if.key_n = ~clr;
        samp(lo);
        inc_if.key_n = 1'b1;
        clr_if.key_n = 1'b1;
        samp(hi);
    endtask

    initial begin
        int base;
        int lat;
        inc_if.key_n = 1'b0;
        clr_if.key_n = 1'b0;
        rst_n        = 1'b0;

        // Reset held with both keys pressed
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check4("rst_dout", dout, 4'd0);
            check1("rst_upd", upd, 1'b0);
        end
        rst_n = 1'b1;
        tick(2 * SD);
        checki("no_upd_before_debounce", upd_cnt, 0);
        exp_q.push_back(4'd0);
        tick(2 * SD);
        checki("both_keys_after_reset", upd_cnt, 1);
        inc_if.key_n = 1'b1;
        clr_if.key_n = 1'b1;
        samp(6);

        // Single press
        exp_q.push_back(4'd1);
        press(1'b1, 1'b0, 5, 6);
        checki("single_press_upd", upd_cnt, 2);
        check4("single_press_dout", dout, 4'd1);

        // Bounce shorter than DEB_CNT samples
        press(1'b1, 1'b0, 2, 1);
        press(1'b1, 1'b0, 2, 6);
        checki("bounce_upd", upd_cnt, 2);
        check4("bounce_dout", dout, 4'd1);

        for (int d = 2; d <= 7; d++) begin
            exp_q.push_back(4'(d));
            press(1'b1, 1'b0, 4, 4);
        end
        check4("count_to_7", dout, 4'd7);

        // Hold for auto-repeat through the 9->0 wrap: updates at samples 3,13,15,17,19
        base = upd_cnt;
        exp_q.push_back(4'd8);
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        press(1'b1, 1'b0, DC + RD + 8, 6);
        checki("repeat_upd_count", upd_cnt - base, 5);
        check4("repeat_dout", dout, 4'd2);

        for (int d = 3; d <= 5; d++) begin
            exp_q.push_back(4'(d));
            press(1'b1, 1'b0, 4, 4);
        end
        check4("count_to_5", dout, 4'd5);

        // Both keys accepted together: clear wins
        base = upd_cnt;
        exp_q.push_back(4'd0);
        press(1'b1, 1'b1, 4, 6);
        checki("clr_inc_single_upd", upd_cnt - base, 1);
        check4("clr_inc_dout", dout, 4'd0);

        // Clear while already zero still pulses UPD
        base = upd_cnt;
        exp_q.push_back(4'd0);
        press(1'b0, 1'b1, 4, 6);
        checki("clr_at_zero_upd", upd_cnt - base, 1);
        check4("clr_at_zero_dout", dout, 4'd0);

        for (int d = 1; d <= 3; d++) begin
            exp_q.push_back(4'(d));
            press(1'b1, 1'b0, 4, 4);
        end

        // Hold into REPEAT at 4, then reset asynchronously mid-cycle
        exp_q.push_back(4'd4);
        inc_if.key_n = 1'b0;
        samp(DC + RD + 1);
        check4("pre_reset_dout", dout, 4'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check4("async_reset_dout", dout, 4'd0);
        check1("async_reset_upd", upd, 1'b0);
        tick(3);
        rst_n = 1'b1;
        exp_q.push_back(4'd1);
        base = upd_cnt;
        lat  = 0;
        while (upd_cnt == base && lat < 40) begin
            tick(1);
            lat++;
        end
        checki("relatch_latency", lat, DC * SD);
        inc_if.key_n = 1'b1;
        samp(6);
        check4("final_dout", dout, 4'd1);
        checki("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
